// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a transmit FIFO.
// The CPU pushes characters into the FIFO. A frame FSM drains the FIFO onto
// the serial line. Status and the serial line are driven from registers.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 868,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          clr_overflow,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity of one character: even = XOR of data bits, odd = its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == 2) begin
      p = ~p;
    end
    return p;
  endfunction

  // FIFO storage and status
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_nxt_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 overflow_r;
  logic                 busy_r;

  // Frame engine
  state_t               state_r;
  logic [BW-1:0]        baud_r;
  logic [3:0]           bit_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r;
  logic                 line_s;
  logic                 uart_tx_r;

  logic                 push_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  // Push uses the registered full, so a pop in the same cycle cannot rescue it.
  assign push_s = wr_en & ~full_r;
  // Pop from IDLE, or on the final stop-bit cycle for gapless back-to-back frames.
  assign pop_s  = ~empty_r & ((state_r == IDLE) |
                  ((state_r == STOP) & (baud_r == BAUD_LAST) & (bit_r == STOP_LAST)));
  assign head_s = mem_r[rd_ptr_r];

  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign uart_tx  = uart_tx_r;

  // Next occupancy from this cycle's push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO data array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, registered status flags and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
      // A dropped push wins over a simultaneous clear.
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end else if (clr_overflow) begin
        overflow_r <= 1'b0;
      end
      // busy mirrors the line: it falls one cycle after the FSM returns to IDLE.
      busy_r <= (state_r != IDLE) | ~empty_r;
    end
  end

  // Serial line level implied by the current FSM state.
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      START:   line_s = 1'b0;
      DATA:    line_s = shift_r[0];
      PAR:     line_s = par_r;
      default: line_s = 1'b1;
    endcase
  end

  // Frame FSM with baud and bit counters; uart_tx lags the state by one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      baud_r    <= '0;
      bit_r     <= 4'd0;
      shift_r   <= '0;
      par_r     <= 1'b0;
      uart_tx_r <= 1'b1;
    end else begin
      uart_tx_r <= line_s;
      case (state_r)
        IDLE: begin
          baud_r <= '0;
          bit_r  <= 4'd0;
          if (pop_s) begin
            shift_r <= head_s;
            par_r   <= calc_parity(head_s);
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            bit_r   <= 4'd0;
            state_r <= DATA;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        DATA: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            shift_r <= shift_r >> 1;
            if (bit_r == DATA_LAST) begin
              bit_r   <= 4'd0;
              state_r <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        PAR: begin
          if (baud_r == BAUD_LAST) begin
            baud_r  <= '0;
            bit_r   <= 4'd0;
            state_r <= STOP;
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        STOP: begin
          if (baud_r == BAUD_LAST) begin
            baud_r <= '0;
            if (bit_r == STOP_LAST) begin
              bit_r <= 4'd0;
              if (pop_s) begin
                shift_r <= head_s;
                par_r   <= calc_parity(head_s);
                state_r <= START;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              bit_r <= bit_r + 4'd1;
            end
          end else begin
            baud_r <= baud_r + BW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= '0;
          bit_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: an 8N1 instance checked every cycle against a
// queue-and-timestamp reference model, plus 7E2 and 7O2 instances for parity.
module tb_uart_tx_fifo;

  localparam int BAUD  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = (1 + 8 + 1) * BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_overflow;
  logic       full, empty, busy, overflow, uart_tx;
  logic [4:0] count;

  logic       wr_en_p;
  logic [6:0] wr_data_p;
  logic       full_e, empty_e, busy_e, ovf_e, tx_e;
  logic       full_o, empty_o, busy_o, ovf_o, tx_o;
  logic [2:0] count_e, count_o;

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .FIFO_DEPTH(DEPTH),
                 .STOP_BITS(1), .PARITY(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .full(full), .empty(empty), .count(count),
    .busy(busy), .overflow(overflow), .uart_tx(uart_tx));

  uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(7), .FIFO_DEPTH(4),
                 .STOP_BITS(2), .PARITY(1)) dut_even (
    .clk(clk), .rst(rst), .wr_en(wr_en_p), .wr_data(wr_data_p),
    .clr_overflow(1'b0), .full(full_e), .empty(empty_e), .count(count_e),
    .busy(busy_e), .overflow(ovf_e), .uart_tx(tx_e));

  uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(7), .FIFO_DEPTH(4),
                 .STOP_BITS(2), .PARITY(2)) dut_odd (
    .clk(clk), .rst(rst), .wr_en(wr_en_p), .wr_data(wr_data_p),
    .clr_overflow(1'b0), .full(full_o), .empty(empty_o), .count(count_o),
    .busy(busy_o), .overflow(ovf_o), .uart_tx(tx_o));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: queue of accepted characters plus the start edge of the
  // most recent frame. A frame owns the transmitter for FRAME cycles.
  logic [7:0] m_q[$];
  logic       m_ovf      = 1'b0;
  int         m_last_s   = -1000;
  logic [7:0] m_last_c   = 8'h00;
  int         m_next_pop = 0;
  logic       m_nonidle  = 1'b0;

  int         tp = -1000;
  logic [6:0] tp_c = 7'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic main_bit(input logic [7:0] c, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return c[i-1];
    return 1'b1;
  endfunction

  function automatic logic par_bit(input logic [6:0] c, input int i, input logic odd);
    if (i == 0) return 1'b0;
    if (i <= 7) return c[i-1];
    if (i == 8) return odd ? ~(^c) : (^c);
    return 1'b1;
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic r, input logic we, input logic [7:0] d, input logic clr);
    int   cnt_b;
    logic exp_busy;
    logic exp_tx;
    int   k;
    rst = r; wr_en = we; wr_data = d; clr_overflow = clr;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0; m_last_s = -1000; m_next_pop = 0;
      exp_busy = 1'b0;
    end else begin
      cnt_b = m_q.size();
      exp_busy = m_nonidle | (cnt_b > 0);
      if (cnt_b > 0 && cyc >= m_next_pop) begin
        m_last_c = m_q.pop_front();
        m_last_s = cyc;
        m_next_pop = cyc + FRAME;
      end
      if (we && cnt_b == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (we && cnt_b < DEPTH) m_q.push_back(d);
    end
    m_nonidle = (cyc >= m_last_s) && (cyc <= m_last_s + FRAME - 1);
    if (cyc >= m_last_s + 1 && cyc <= m_last_s + FRAME)
      exp_tx = main_bit(m_last_c, (cyc - m_last_s - 1) / BAUD);
    else
      exp_tx = 1'b1;
    #1;
    chk("uart_tx", uart_tx, exp_tx);
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("busy", busy, exp_busy);
    chk("overflow", overflow, m_ovf);
    k = cyc - tp;
    if (k >= 1 && k <= 50) begin
      chk("tx_even", tx_e, (k >= 2 && k <= 45) ? par_bit(tp_c, (k - 2) / BAUD, 1'b0) : 1'b1);
      chk("tx_odd",  tx_o, (k >= 2 && k <= 45) ? par_bit(tp_c, (k - 2) / BAUD, 1'b1) : 1'b1);
      chk("busy_even", busy_e, k <= 45);
      chk("busy_odd",  busy_o, k <= 45);
    end
  endtask

  initial begin
    int   t0;
    int   pct;
    logic r;
    wr_en_p = 1'b0; wr_data_p = 7'h00;

    // Reset for two cycles, then idle.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("idle_tx", uart_tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    // Single 8N1 frame of 0xA5.
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (cyc - t0 == 1) chk("a5_pre", uart_tx, 1'b1);
      if (cyc - t0 == 2) chk("a5_start0", uart_tx, 1'b0);
      if (cyc - t0 == 5) chk("a5_start3", uart_tx, 1'b0);
      if (cyc - t0 == 6) chk("a5_bit0", uart_tx, 1'b1);
      if (cyc - t0 == 10) chk("a5_bit1", uart_tx, 1'b0);
      if (cyc - t0 == 34) chk("a5_bit7", uart_tx, 1'b1);
      if (cyc - t0 == 38) chk("a5_stop", uart_tx, 1'b1);
      if (cyc - t0 == 41) chk("a5_busy41", busy, 1'b1);
      if (cyc - t0 == 42) chk("a5_busy42", busy, 1'b0);
    end

    // Back-to-back frames with no idle gap.
    step(1'b0, 1'b1, 8'h55, 1'b0);
    t0 = cyc;
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 85; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (cyc - t0 == 41) chk("b2b_stop", uart_tx, 1'b1);
      if (cyc - t0 == 41) chk("b2b_empty", empty, 1'b1);
      if (cyc - t0 == 42) chk("b2b_start", uart_tx, 1'b0);
      if (cyc - t0 == 81) chk("b2b_busy81", busy, 1'b1);
      if (cyc - t0 == 82) chk("b2b_busy82", busy, 1'b0);
    end

    // Overflow: 18 back-to-back pushes from idle.
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b0);
      if (i == 1) chk("ovf_cnt1", count, 5'd1);
      if (i == 16) chk("ovf_full16", full, 1'b1);
      if (i == 16) chk("ovf_cnt16", count, 5'd16);
      if (i == 16) chk("ovf_flag16", overflow, 1'b0);
      if (i == 17) chk("ovf_flag17", overflow, 1'b1);
      if (i == 17) chk("ovf_cnt17", count, 5'd16);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", overflow, 1'b0);
    chk("ovf_clr_full", full, 1'b1);
    for (int i = 0; i < 700; i++) step(1'b0, 1'b0, 8'h00, 1'b0);

    // Parity: push 0x07 into the 7E2 and 7O2 instances.
    wr_en_p = 1'b1; wr_data_p = 7'h07;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    tp = cyc; tp_c = 7'h07;
    wr_en_p = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (cyc - tp == 35) chk("even_par", tx_e, 1'b1);
      if (cyc - tp == 35) chk("odd_par", tx_o, 1'b0);
      if (cyc - tp == 43) chk("even_stop2", tx_e, 1'b1);
      if (cyc - tp == 46) chk("even_busy_fall", busy_e, 1'b0);
    end

    // Reset during the DATA state of the first of three frames.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    t0 = cyc;
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_data_low", uart_tx, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_tx", uart_tx, 1'b1);
    chk("mid_rst_cnt", count, 5'd0);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("mid_quiet", uart_tx, 1'b1);
    end

    // Randomised traffic: alternating light and bursty phases, rare clears and resets.
    for (int i = 0; i < 3000; i++) begin
      pct = ((i / 200) % 2 == 0) ? 4 : 60;
      r = ($urandom_range(0, 499) == 0);
      step(r, ($urandom_range(0, 99) < pct), 8'($urandom),
           ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 800; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("final_empty", empty, 1'b1);
    chk("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Memory-mapped UART transmitter with a transmit FIFO. It is the successor to the single-byte UART used behind the UART store address. The CPU store path pushes characters without waiting for the serial line, and the CPU can poll full, empty, busy and overflow status. Baud divisor, data width, FIFO depth, stop bits and parity are all build-time parameters.

Parameters:
BAUD_DIV, 868, clock cycles per serial bit (>=2); 868 gives 115200 baud at 100 MHz.
DATA_BITS, 8, character width, 5..9.
FIFO_DEPTH, 16, FIFO entries; must be a power of two, >=2.
STOP_BITS, 1, number of stop bits, 1 or 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  push request, sampled on posedge clk
wr_data  input  DATA_BITS  character to push
clr_overflow  input  1  clears the overflow flag
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  high while a frame is in flight or the FIFO is non-empty
overflow  output  1  sticky flag: a push was dropped
uart_tx  output  1  serial line, idles high

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk.
- Outputs at reset:
  - uart_tx=1, full=0, empty=1, count=0, busy=0, overflow=0.
  - FSM returns to IDLE, and the FIFO read and write pointers return to 0.
- Reset mid-frame: the frame is aborted and the FIFO is flushed; uart_tx is 1 on the cycle after rst is sampled.
- Push:
  - wr_en with full==0 stores wr_data at a posedge.
  - wr_en with full==1 drops the data and sets overflow=1; "full" is the value at the start of that cycle, so a same-cycle pop does not save the push.
- overflow clears only on clr_overflow=1 or rst. If a drop and clr_overflow happen in the same cycle, overflow is set (set wins).
- Simultaneous push and pop: count is unchanged and both operations complete.
- Pointers wrap modulo FIFO_DEPTH. count = push minus pop; full = (count==FIFO_DEPTH); empty = (count==0). All status outputs are registered.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop the head into the shift register, clear the baud counter and go to START. Otherwise stay in IDLE.
  - START: uart_tx=0. After BAUD_DIV cycles, go to DATA.
  - DATA: send DATA_BITS bits LSB first, each for BAUD_DIV cycles. Then go to PAR if PARITY!=0, else go to STOP.
  - PAR: send the parity bit for BAUD_DIV cycles. Even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: uart_tx=1 for STOP_BITS*BAUD_DIV cycles. On the last cycle, if the FIFO is not empty, pop and go to START (zero idle cycles between frames). Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps.
  - A bit boundary occurs at BAUD_DIV-1.
  - Width is $clog2(BAUD_DIV).
- Latency: a push at posedge N into an empty FIFO with the FSM in IDLE is popped at N+1, and uart_tx=0 from N+2.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- uart_tx is driven from a register and is glitch-free.
- busy = (state!=IDLE) | !empty. busy deasserts in the cycle after the last stop cycle when no further data is queued.
- A store to the UART address drives wr_en=1 for one cycle. Software polls full before writing, or ignores it and checks overflow afterwards.

Test Plan:
1. Reset then idle, BAUD_DIV=4, 8N1: hold rst for 2 cycles, then idle 20 cycles -> uart_tx=1, empty=1, busy=0, count=0 throughout.
2. Single frame, BAUD_DIV=4, 8N1: push 0xA5 at cycle 0 -> uart_tx=0 during cycles 2..5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 during cycles 38..41; busy falls at cycle 42 and the frame is 40 cycles long.
3. Even parity, 7E2, BAUD_DIV=4: push 0x07 -> parity bit 1, two stop bits, frame 44 cycles; with PARITY=2 the same push gives parity bit 0.
4. Overflow, FIFO_DEPTH=16, BAUD_DIV=868: 18 back-to-back pushes from idle -> push 0 is popped, count=16, full=1 after push 17; push 18 is dropped and overflow=1; clr_overflow=1 clears it while full stays 1.
5. Back-to-back frames, BAUD_DIV=4, 8N1: push 0x55 and 0xAA on consecutive cycles -> the second start bit begins on the cycle right after the first frame's last stop cycle (0 idle cycles); total 80 cycles; empty=1 after the second pop.
6. Reset mid-frame, BAUD_DIV=4, 8N1: three pushes, assert rst during the DATA state of the first frame -> uart_tx=1 on the next cycle, count=0, no further start bits for 100 cycles.
